// File: rtl/keyboard_pkg.sv
// Shared PS/2 scan-code constants and types for the keyboard front-end.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_OVR    = 8'hFF;

  typedef logic [8:0] keycode_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Keyboard status/response bytes that must never be treated as key codes.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return b inside {SC_ERR0, SC_OVR, SC_BAT_OK, SC_ACK, SC_ECHO, SC_RESEND};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, 11-bit
// frame FSM with odd-parity/stop checks and an inter-edge timeout.
module ps2_frame_rx
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]       clk_sync_q, dat_sync_q;
  logic             filt_q, filt_d, filt_dly_q;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
  rx_state_t        state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       byte_data_q, byte_data_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fall, din;

  assign din  = dat_sync_q[1];
  assign fall = filt_dly_q & ~filt_q;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      filt_cnt_d = filt_cnt_q + FLT_W'(1);
      if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        filt_d     = clk_sync_q[1];
        filt_cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    byte_data_d  = byte_data_q;
    tmo_d        = tmo_q;
    if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: if (!din) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shreg_d   = {din, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din && (^{shreg_q, par_q})) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != IDLE) begin
      // A stalled frame is abandoned so the next start bit resynchronises.
      if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
        tmo_d       = '0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_q       <= 1'b1;
      filt_dly_q   <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_data_q  <= '0;
      tmo_q        <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[0], ps2_clk};
      dat_sync_q   <= {dat_sync_q[0], ps2_data};
      filt_q       <= filt_d;
      filt_dly_q   <= filt_q;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      byte_data_q  <= byte_data_d;
      tmo_q        <= tmo_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front-end: E0/F0 prefix tracking and held/press/release
// state for a configurable table of scan codes.
module ps2_key_tracker
  import keyboard_pkg::*;
#(
  parameter int                 NKEYS          = 4,
  parameter logic [9*NKEYS-1:0] KEY_CODES      = {{1'b1, SC_DOWN}, {1'b1, SC_UP},
                                                  {1'b0, SC_S},    {1'b0, SC_W}},
  parameter int                 FILTER_LEN     = 8,
  parameter int                 TIMEOUT_CYCLES = 200_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PS2Clk,
  input  logic             PS2Data,
  input  logic             clr_keys,
  output logic [NKEYS-1:0] key_held,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             frame_err
);

  logic             ext_q, ext_d, brk_q, brk_d;
  logic [NKEYS-1:0] held_q, held_d, press_q, press_d, rel_q, rel_d;
  keycode_t         code;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (PS2Clk),
    .ps2_data   (PS2Data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign code = {ext_q, byte_data};

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    held_d  = held_q;
    press_d = '0;
    rel_d   = '0;
    if (clr_keys) begin
      held_d = '0;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
    end else if (frame_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid) begin
      if (byte_data == SC_EXT) begin
        ext_d = 1'b1;
      end else if (byte_data == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (!is_ctrl_byte(byte_data)) begin
          // Duplicate table entries all follow the same code.
          for (int i = 0; i < NKEYS; i++) begin
            if (KEY_CODES[9*i +: 9] == code) begin
              if (brk_q) begin
                held_d[i] = 1'b0;
                rel_d[i]  = held_q[i];
              end else begin
                held_d[i]  = 1'b1;
                press_d[i] = ~held_q[i];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed table, hand-written
// corner sequences and randomized frames against a scan-code model.
module tb_ps2_key_tracker;

  localparam int NKEYS = 4;
  localparam int HALF  = 20;
  localparam int GAP   = 30;
  localparam int TMO   = 600;

  logic             clk = 1'b0;
  logic             rst, PS2Clk, PS2Data, clr_keys;
  logic [NKEYS-1:0] key_held, key_press, key_release;
  logic             byte_valid, frame_err;
  logic [7:0]       byte_data;

  ps2_key_tracker #(
    .NKEYS          (NKEYS),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PS2Clk      (PS2Clk),
    .PS2Data     (PS2Data),
    .clr_keys    (clr_keys),
    .key_held    (key_held),
    .key_press   (key_press),
    .key_release (key_release),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse counters; every strobe cycle is counted, so a 2-cycle pulse shows as 2.
  int bv_cnt = 0;
  int err_cnt = 0;
  int press_cnt[NKEYS] = '{default: 0};
  int rel_cnt[NKEYS]   = '{default: 0};

  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_cnt <= bv_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    for (int k = 0; k < NKEYS; k++) begin
      if (key_press[k] === 1'b1) press_cnt[k] <= press_cnt[k] + 1;
      if (key_release[k] === 1'b1) rel_cnt[k] <= rel_cnt[k] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int               kc[NKEYS] = '{'h01D, 'h01B, 'h175, 'h172};
  bit               m_ext, m_brk;
  logic [NKEYS-1:0] m_held;
  logic [7:0]       m_last;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = '0; m_last = 8'h00;
  endtask

  task automatic model_apply(input logic [7:0] b, input bit good,
                             output logic [NKEYS-1:0] ep, output logic [NKEYS-1:0] er);
    ep = '0; er = '0;
    if (!good) begin
      m_ext = 0; m_brk = 0;
      return;
    end
    m_last = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!(b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFE})) begin
        for (int k = 0; k < NKEYS; k++) begin
          if (kc[k] == (int'(m_ext) * 256 + int'(b))) begin
            if (m_brk) begin
              if (m_held[k]) er[k] = 1'b1;
              m_held[k] = 1'b0;
            end else begin
              if (!m_held[k]) ep[k] = 1'b1;
              m_held[k] = 1'b1;
            end
          end
        end
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  function automatic logic [2*NKEYS-1:0] expand(input logic [NKEYS-1:0] v);
    logic [2*NKEYS-1:0] r = '0;
    for (int k = 0; k < NKEYS; k++) r[2*k +: 2] = {1'b0, v[k]};
    return r;
  endfunction

  // ---------------- PS/2 driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    PS2Data = b;
    if (glitch) begin
      tick(8); PS2Clk = 1'b0; tick(3); PS2Clk = 1'b1; tick(HALF - 11);
    end else tick(HALF);
    PS2Clk = 1'b0;
    if (glitch) begin
      tick(8); PS2Clk = 1'b1; tick(3); PS2Clk = 1'b0; tick(HALF - 11);
    end else tick(HALF);
    PS2Clk = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop
  task automatic send_frame(input logic [7:0] b, input int kind, input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {(kind != 2), (~^b) ^ (kind == 1), b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], glitch);
    PS2Data = 1'b1;
    tick(GAP);
  endtask

  typedef struct {
    logic [NKEYS-1:0]   held;
    logic [2*NKEYS-1:0] press, rel;
    int                 bv, err;
    logic [7:0]         bdata;
  } obs_t;

  task automatic observe(input logic [7:0] b, input int kind, input bit glitch, output obs_t o);
    int bv0, er0;
    int p0[NKEYS], r0[NKEYS];
    bv0 = bv_cnt; er0 = err_cnt;
    for (int k = 0; k < NKEYS; k++) begin p0[k] = press_cnt[k]; r0[k] = rel_cnt[k]; end
    send_frame(b, kind, 11, glitch);
    o.held = key_held; o.bdata = byte_data;
    o.bv = bv_cnt - bv0; o.err = err_cnt - er0;
    for (int k = 0; k < NKEYS; k++) begin
      o.press[2*k +: 2] = (press_cnt[k] - p0[k] > 3) ? 2'd3 : 2'(press_cnt[k] - p0[k]);
      o.rel[2*k +: 2]   = (rel_cnt[k] - r0[k] > 3) ? 2'd3 : 2'(rel_cnt[k] - r0[k]);
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int kind, input bit glitch, input string tag);
    logic [NKEYS-1:0] ep, er;
    obs_t o;
    model_apply(b, kind == 0, ep, er);
    observe(b, kind, glitch, o);
    chk({tag, "_held"}, 32'(o.held), 32'(m_held));
    chk({tag, "_press"}, 32'(o.press), 32'(expand(ep)));
    chk({tag, "_release"}, 32'(o.rel), 32'(expand(er)));
    chk({tag, "_bvalid"}, o.bv, (kind == 0) ? 1 : 0);
    chk({tag, "_ferr"}, o.err, (kind == 0) ? 0 : 1);
    chk({tag, "_bdata"}, 32'(o.bdata), 32'(m_last));
  endtask

  typedef struct {
    logic [7:0]       b;
    int               kind;
    logic [NKEYS-1:0] held, press, rel;
    bit               err;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [NKEYS-1:0] ep, er;
    obs_t o;
    bit found;
    int bv0, er0;
    logic [7:0] pool[12];

    rst = 1'b1; PS2Clk = 1'b1; PS2Data = 1'b1; clr_keys = 1'b0;
    model_reset();
    tick(5);
    chk("reset_outputs", 32'({key_held, key_press, key_release, byte_valid, byte_data, frame_err}), 32'd0);
    rst = 1'b0;
    tick(5);

    // W make with latency: held/press appear exactly one cycle after byte_valid.
    model_apply(8'h1D, 1, ep, er);
    found = 0;
    fork
      send_frame(8'h1D, 0, 11, 0);
      begin
        for (int i = 0; i < 3000 && !found; i++) begin
          @(negedge clk);
          if (byte_valid === 1'b1) found = 1;
        end
        chk("t1_bvalid_seen", 32'(found), 32'd1);
        if (found) begin
          chk("t1_bdata", 32'(byte_data), 32'h1D);
          chk("t1_held_before", 32'(key_held), 32'd0);
          @(negedge clk);
          chk("t1_held", 32'(key_held), 32'b0001);
          chk("t1_press", 32'(key_press), 32'b0001);
          @(negedge clk);
          chk("t1_press_gone", 32'(key_press), 32'd0);
        end
      end
    join

    vt[0]  = '{8'hE0, 0, 4'b0001, 4'b0000, 4'b0000, 0};
    vt[1]  = '{8'h75, 0, 4'b0101, 4'b0100, 4'b0000, 0};
    vt[2]  = '{8'hE0, 0, 4'b0101, 4'b0000, 4'b0000, 0};
    vt[3]  = '{8'h75, 0, 4'b0101, 4'b0000, 4'b0000, 0};
    vt[4]  = '{8'hE0, 0, 4'b0101, 4'b0000, 4'b0000, 0};
    vt[5]  = '{8'hF0, 0, 4'b0101, 4'b0000, 4'b0000, 0};
    vt[6]  = '{8'h75, 0, 4'b0001, 4'b0000, 4'b0100, 0};
    vt[7]  = '{8'h1B, 1, 4'b0001, 4'b0000, 4'b0000, 1};
    vt[8]  = '{8'hE0, 0, 4'b0001, 4'b0000, 4'b0000, 0};
    vt[9]  = '{8'h1D, 2, 4'b0001, 4'b0000, 4'b0000, 1};
    vt[10] = '{8'h72, 0, 4'b0001, 4'b0000, 4'b0000, 0};
    vt[11] = '{8'hF0, 0, 4'b0001, 4'b0000, 4'b0000, 0};
    vt[12] = '{8'h1D, 0, 4'b0000, 4'b0000, 4'b0001, 0};
    for (int i = 0; i < 13; i++) begin
      model_apply(vt[i].b, vt[i].kind == 0, ep, er);
      observe(vt[i].b, vt[i].kind, 0, o);
      chk($sformatf("tbl%0d_held", i), 32'(o.held), 32'(vt[i].held));
      chk($sformatf("tbl%0d_press", i), 32'(o.press), 32'(expand(vt[i].press)));
      chk($sformatf("tbl%0d_release", i), 32'(o.rel), 32'(expand(vt[i].rel)));
      chk($sformatf("tbl%0d_ferr", i), o.err, vt[i].err ? 1 : 0);
      chk($sformatf("tbl%0d_bvalid", i), o.bv, vt[i].err ? 0 : 1);
    end

    // Clock stalls after start + 4 data bits.
    bv0 = bv_cnt; er0 = err_cnt;
    send_frame(8'h1D, 0, 5, 0);
    tick(TMO + 50);
    chk("tmo_ferr", err_cnt - er0, 1);
    chk("tmo_no_bvalid", bv_cnt - bv0, 0);
    model_apply(8'h1D, 0, ep, er);
    run_frame(8'h1D, 0, 0, "after_tmo");

    run_frame(8'h1B, 0, 1, "glitch");

    run_frame(8'hF0, 0, 0, "rel_s_pfx");
    run_frame(8'h1B, 0, 0, "rel_s");
    run_frame(8'hE0, 0, 0, "down_pfx");
    run_frame(8'h72, 0, 0, "down");
    chk("w_down_held", 32'(key_held), 32'b1001);

    // clr_keys lands on the same cycle as the byte_valid for S.
    bv0 = bv_cnt;
    begin
      int p0[NKEYS], r0[NKEYS];
      for (int k = 0; k < NKEYS; k++) begin p0[k] = press_cnt[k]; r0[k] = rel_cnt[k]; end
      found = 0;
      fork
        send_frame(8'h1B, 0, 11, 0);
        begin
          for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (byte_valid === 1'b1) found = 1;
          end
          clr_keys = found;
          @(negedge clk);
          clr_keys = 1'b0;
        end
      join
      chk("clr_bvalid_seen", 32'(found), 32'd1);
      chk("clr_held", 32'(key_held), 32'd0);
      for (int k = 0; k < NKEYS; k++) begin
        chk($sformatf("clr_press%0d", k), press_cnt[k] - p0[k], 0);
        chk($sformatf("clr_rel%0d", k), rel_cnt[k] - r0[k], 0);
      end
    end
    model_reset();
    m_last = 8'h1B;

    // Reset in the middle of a frame.
    send_frame(8'h75, 0, 6, 0);
    rst = 1'b1;
    tick(3);
    chk("midrst_outputs", 32'({key_held, key_press, key_release, byte_valid, byte_data, frame_err}), 32'd0);
    rst = 1'b0;
    model_reset();
    tick(5);
    run_frame(8'h1D, 0, 0, "after_rst");

    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'hEE, 8'hFE};
    for (int n = 0; n < 60; n++) begin
      logic [7:0] b;
      int kind, r;
      if ($urandom_range(0, 11) == 0) begin
        clr_keys = 1'b1; tick(1); clr_keys = 1'b0; tick(1);
        m_held = '0; m_ext = 0; m_brk = 0;
        chk($sformatf("rnd%0d_clr", n), 32'(key_held), 32'd0);
      end
      r = $urandom_range(0, 19);
      b = (r < 12) ? pool[r] : ((r < 17) ? pool[$urandom_range(0, 5)] : 8'($urandom));
      r = $urandom_range(0, 19);
      kind = (r < 2) ? 1 : ((r == 2) ? 2 : 0);
      run_frame(b, kind, $urandom_range(0, 4) == 0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
Parametrised PS/2 keyboard front-end that replaces the fixed up/down decoder path. Receives raw PS/2 clock/data and deserialises frames with parity, stop and timeout checking. Tracks E0 (extended) and F0 (break) prefixes and maintains a held-state bit for each of NKEYS configurable scan codes, with press/release strobes. Feeds paddle control for both players (game FSM, paddle movement) from a single keyboard.

Parameters:
NKEYS, 4, number of tracked keys
KEY_CODES, {9'h172, 9'h175, 9'h01B, 9'h01D}, packed NKEYS x 9 bits; index i = bits [9i+8:9i]; bit 8 = extended (E0) flag, bits 7:0 = make code; default i0=W, i1=S, i2=Up, i3=Down
FILTER_LEN, 8, PS2Clk glitch filter length in clk cycles
TIMEOUT_CYCLES, 200_000, maximum clk cycles between PS/2 falling edges inside a frame

Ports:
clk  in  1  system clock; sole clock domain
rst  in  1  synchronous, active-high reset
PS2Clk  in  1  raw PS/2 clock, asynchronous
PS2Data  in  1  raw PS/2 data, asynchronous
clr_keys  in  1  synchronous clear of all held states
key_held  out  NKEYS  1 while key i is pressed
key_press  out  NKEYS  1-cycle strobe on key i make; typematic repeats excluded
key_release  out  NKEYS  1-cycle strobe on key i break
byte_valid  out  1  1-cycle strobe, good byte received
byte_data  out  8  last good byte; held until next byte_valid
frame_err  out  1  1-cycle strobe on parity, stop or timeout error

Behaviour:
- Reset: all outputs 0; FSM IDLE; ext/brk flags 0; filter state 1; timeout counter 0.
- Input conditioning: PS2Clk and PS2Data each pass through a 2-FF synchroniser. The filtered clock changes only after FILTER_LEN consecutive equal synchronised samples. A falling edge of the filtered clock samples synchronised PS2Data.
- Frame FSM (ps2_frame_rx), advanced on each sample:
  - IDLE: sample 0 -> DATA (bit count 0). Sample 1 is ignored; stay IDLE, no error.
  - DATA: 8 bits, LSB first -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if stop = 1 and odd parity over data+parity holds, byte_valid = 1 on the next clk; otherwise frame_err = 1. Return to IDLE in both cases.
- Timeout: the counter clears on every sample and counts while the FSM is not IDLE. Reaching TIMEOUT_CYCLES -> frame_err pulse, FSM to IDLE, partial byte discarded.
- Decoder, acting on byte_valid:
  - E0: set ext.
  - F0: set brk.
  - 00, FF (overrun), AA, FA, EE, FE: clear ext and brk; no key effect.
  - Any other byte: form code = {ext, byte}; every index i with KEY_CODES[i] == code updates (duplicate entries all update).
    - brk = 0: key_held[i] <= 1; key_press[i] pulses only if key_held[i] was 0.
    - brk = 1: key_held[i] <= 0; key_release[i] pulses only if key_held[i] was 1.
    - Then clear ext and brk.
- Any frame_err clears ext and brk, so a later byte is never misattributed.
- Latency: byte_valid is 1 clk after the filtered falling edge of the stop bit. key_held, key_press and key_release are registered 1 clk after the byte_valid of the final code byte.
- clr_keys: key_held <= 0 with no release strobes; ext/brk cleared. Priority is rst > clr_keys > decoder update in the same cycle.
- Reset mid-frame aborts the frame; the next frame must start with a fresh start bit.
- Independent keys are fully concurrent, e.g. W and Up held together.

Decomposition:
- keyboard_pkg:
  - Scan-code localparams: SC_EXT=8'hE0, SC_BRK=8'hF0, SC_W, SC_S, SC_UP, SC_DOWN, SC_BAT_OK=8'hAA, SC_ACK=8'hFA, etc.
  - typedef keycode_t (9-bit: ext + code).
  - typedef rx_state_t enum {IDLE, DATA, PARITY, STOP}.
- Sub-module ps2_frame_rx: synchroniser, filter, frame FSM and timeout. Outputs byte_valid, byte_data, frame_err.
- Top: prefix flags and key table.

Test Plan:
1. Frame 1D (W make) at 10 kHz PS/2 clock -> byte_valid with byte_data=8'h1D; next clk key_held=4'b0001, key_press=4'b0001 for exactly 1 cycle.
2. Frames E0 75, E0 75 (repeat), then E0 F0 75 -> key_held[2] set once; key_press[2] pulses once only; after the final 75, key_held[2]=0 and key_release[2] pulses once.
3. Frame 1B with parity bit flipped -> frame_err pulse; no byte_valid; key_held unchanged. Then E0, a bad frame, then 72 -> key_held[1] and key_held[3] both stay 0, since the error cleared ext.
4. PS2Clk stops after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE. A following good 1D frame is received correctly.
5. 3-cycle glitch pulses on PS2Clk with FILTER_LEN=8 during a frame -> no extra bits sampled; byte received correctly.
6. Hold W and Down (key_held=4'b1001), then assert clr_keys together with a byte_valid for 1B -> key_held=4'b0000, no release or press strobes; rst mid-frame -> all outputs 0, next frame decoded cleanly.
